// File: rtl/asm_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock after a
// one-cycle divisor check, with a single-cycle result-valid pulse.
module asm_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             S,
    output logic             busy,
    output logic             V,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] dvd_nx;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] dsr_nx;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] r_nx;
    logic             dz_nx;
    logic             v_nx;
    logic             busy_nx;

    logic [WIDTH+1:0] step_sh;
    logic             step_ge;
    logic [WIDTH:0]   step_sub;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_dvd;

    // One restoring step: shift {rem, dvd} left, subtract divisor when it fits.
    always_comb begin
        step_sh  = {rem, dvd[WIDTH-1]};
        step_ge  = (step_sh >= {2'b00, dsr});
        step_sub = step_sh[WIDTH:0] - {1'b0, dsr};
        step_rem = step_ge ? step_sub : step_sh[WIDTH:0];
        step_dvd = {dvd[WIDTH-2:0], step_ge};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (S) state_nx = CHECK;
            CHECK:   state_nx = (dsr == '0) ? IDLE : RUN;
            RUN:     if (cnt == CW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dvd_nx  = dvd;
        rem_nx  = rem;
        dsr_nx  = dsr;
        cnt_nx  = cnt;
        q_nx    = quotient;
        r_nx    = remainder;
        dz_nx   = div_by_zero;
        v_nx    = 1'b0;
        busy_nx = (state_nx != IDLE);
        case (state)
            IDLE: begin
                if (S) begin
                    dvd_nx = in1;
                    dsr_nx = in2;
                    rem_nx = '0;
                    cnt_nx = CW'(WIDTH);
                end
            end
            CHECK: begin
                if (dsr == '0) begin
                    q_nx  = '1;
                    r_nx  = dvd;
                    dz_nx = 1'b1;
                    v_nx  = 1'b1;
                end
            end
            RUN: begin
                dvd_nx = step_dvd;
                rem_nx = step_rem;
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    q_nx  = step_dvd;
                    r_nx  = step_rem[WIDTH-1:0];
                    dz_nx = 1'b0;
                    v_nx  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dvd         <= '0;
            rem         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            V           <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dvd         <= dvd_nx;
            rem         <= rem_nx;
            dsr         <= dsr_nx;
            cnt         <= cnt_nx;
            quotient    <= q_nx;
            remainder   <= r_nx;
            div_by_zero <= dz_nx;
            V           <= v_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_asm_divider.sv
// Bench for asm_divider: a latency/result model checked every cycle, plus
// directed operations with hand-computed quotients, remainders and latencies.
module tb_asm_divider;

    localparam int unsigned WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             S = 1'b0;
    logic             busy;
    logic             V;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    asm_divider #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in1         (in1),
        .in2         (in2),
        .S           (S),
        .busy        (busy),
        .V           (V),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result = plain / and %, valid one edge after capture for a
    // zero divisor and WIDTH+1 edges after capture otherwise.
    logic             m_busy = 1'b0;
    logic             m_v = 1'b0;
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_r = '0;
    logic             m_dz = 1'b0;
    logic [WIDTH-1:0] p_q = '0;
    logic [WIDTH-1:0] p_r = '0;
    logic             p_dz = 1'b0;
    int               m_left = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_v    = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_dz   = 1'b0;
            m_left = 0;
        end else begin
            m_v = 1'b0;
            if (!m_busy) begin
                if (S) begin
                    m_busy = 1'b1;
                    if (in2 == '0) begin
                        m_left = 1;
                        p_q    = '1;
                        p_r    = in1;
                        p_dz   = 1'b1;
                    end else begin
                        m_left = WIDTH + 1;
                        p_q    = in1 / in2;
                        p_r    = in1 % in2;
                        p_dz   = 1'b0;
                    end
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_v    = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dz   = p_dz;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("busy", WIDTH'(busy), WIDTH'(m_busy));
        check("V", WIDTH'(V), WIDTH'(m_v));
        check("quotient", quotient, m_q);
        check("remainder", remainder, m_r);
        check("div_by_zero", WIDTH'(div_by_zero), WIDTH'(m_dz));
    end

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clock);
        in1 = a;
        in2 = b;
        S   = 1'b1;
        @(negedge clock);
        S   = 1'b0;
    endtask

    // Count edges from the capture edge until V is seen; bounded.
    task automatic wait_v(output int lat);
        lat = 0;
        while (V !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (V !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_v: timeout, V never rose at %0t", $time);
        end
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                          input logic dz, input int lat_exp);
        int lat;
        start_op(a, b);
        wait_v(lat);
        check({name, "_latency"}, WIDTH'(lat), WIDTH'(lat_exp));
        check({name, "_q"}, quotient, q);
        check({name, "_r"}, remainder, r);
        check({name, "_dz"}, WIDTH'(div_by_zero), WIDTH'(dz));
        @(negedge clock);
        check({name, "_v_drop"}, WIDTH'(V), '0);
        check({name, "_q_hold"}, quotient, q);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2, 1'b0, 33};
        vecs[1] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5, 1'b1, 1};
        vecs[2] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0, 1'b0, 33};
        vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3, 1'b0, 33};
        vecs[4] = '{32'd7,          32'd7,          32'd1,          32'd0, 1'b0, 33};
        vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0, 1'b0, 33};
        vecs[6] = '{32'h80000000,   32'd3,          32'd715827882,  32'd2, 1'b0, 33};
        vecs[7] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0, 1'b0, 33};

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", WIDTH'(busy), '0);
        check("rst_V", WIDTH'(V), '0);
        check("rst_q", quotient, '0);
        check("rst_r", remainder, '0);
        check("rst_dz", WIDTH'(div_by_zero), '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);

        // S held high through RUN with changing operands; restart at V-drop edge.
        @(negedge clock);
        in1 = 32'd100;
        in2 = 32'd7;
        S   = 1'b1;
        @(negedge clock);
        in1 = 32'd9;
        in2 = 32'd3;
        wait_v(lat);
        check("b2b_first_latency", WIDTH'(lat), WIDTH'(33));
        check("b2b_first_q", quotient, 32'd14);
        check("b2b_first_r", remainder, 32'd2);
        @(negedge clock);
        S = 1'b0;
        check("b2b_v_drop", WIDTH'(V), '0);
        check("b2b_busy_restart", WIDTH'(busy), WIDTH'(1));
        wait_v(lat);
        check("b2b_second_latency", WIDTH'(lat), WIDTH'(33));
        check("b2b_second_q", quotient, 32'd3);
        check("b2b_second_r", remainder, 32'd0);
        @(negedge clock);

        // Reset mid-operation aborts with no V pulse.
        start_op(32'd1000, 32'd3);
        repeat (9) @(negedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy", WIDTH'(busy), '0);
        check("abort_V", WIDTH'(V), '0);
        check("abort_q", quotient, '0);
        check("abort_r", remainder, '0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_no_v_q", quotient, '0);
        run_op("after_abort", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 33);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
